instr_sequencer: RTL and testbench

Fetch/decode/execute control sequencer that sits directly upstream of the CPU datapath (program counter, ALU, register file, shared 16-bit bus). It fetches 16-bit instruction words over a ready-handshaked memory port, decodes them, and issues the one-hot-per-cycle bus-driver enables and load strobes that step the datapath.

---
 rtl/instr_sequencer_if.sv | 31 +++
 rtl/instr_sequencer.sv | 103 ++++++++++
 tb/tb_instr_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: memory port and datapath control bundle between sequencer and datapath
interface instr_sequencer_if;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  flags;
    logic        mem_req;
    logic        pc_out_en;
    logic        pc_inc;
    logic        pc_load;
    logic        imm_out_en;
    logic [15:0] imm;
    logic [15:0] ir;
    logic [3:0]  reg_src;
    logic [3:0]  reg_dst;
    logic        reg_out_en;
    logic        reg_we;
    logic        alu_en;
    logic [2:0]  alu_op;
    logic        halted;
    logic        illegal;
    modport master (
        input  mem_rdata, mem_ready, flags,
        output mem_req, pc_out_en, pc_inc, pc_load, imm_out_en, imm, ir,
               reg_src, reg_dst, reg_out_en, reg_we, alu_en, alu_op, halted, illegal
    );
    modport slave (
        output mem_rdata, mem_ready, flags,
        input  mem_req, pc_out_en, pc_inc, pc_load, imm_out_en, imm, ir,
               reg_src, reg_dst, reg_out_en, reg_we, alu_en, alu_op, halted, illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/execute control FSM issuing one-cycle bus enables and load strobes
module instr_sequencer #(
    parameter bit RESET_STATE_FETCH = 1'b1
) (
    input logic clk,
    input logic r,
    instr_sequencer_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, OPERAND, EXEC, WB, HALT} state_t;
    state_t state, next;
    logic [15:0] ir, imm;
    logic illegal, set_illegal;
    logic [3:0] op;
    assign op = ir[15:12];
    assign bus.ir = ir;
    assign bus.imm = imm;
    assign bus.illegal = illegal;
    always_ff @(posedge clk) begin
        if (r) begin
            // a non-1 value is reserved; park in HALT so misuse is obvious
            state <= RESET_STATE_FETCH ? FETCH : HALT;
            ir <= '0;
            imm <= '0;
            illegal <= 1'b0;
        end else begin
            state <= next;
            if (state == FETCH && bus.mem_ready) ir <= bus.mem_rdata;
            if (state == OPERAND && bus.mem_ready) imm <= bus.mem_rdata;
            if (set_illegal) illegal <= 1'b1;
        end
    end
    always_comb begin
        next = state;
        set_illegal = 1'b0;
        bus.mem_req = 1'b0;
        bus.pc_out_en = 1'b0;
        bus.pc_inc = 1'b0;
        bus.pc_load = 1'b0;
        bus.imm_out_en = 1'b0;
        bus.reg_src = '0;
        bus.reg_dst = '0;
        bus.reg_out_en = 1'b0;
        bus.reg_we = 1'b0;
        bus.alu_en = 1'b0;
        bus.alu_op = '0;
        bus.halted = 1'b0;
        if (!r) begin
            case (state)
                FETCH, OPERAND: begin
                    bus.mem_req = 1'b1;
                    bus.pc_out_en = 1'b1;
                    bus.pc_inc = bus.mem_ready;
                    if (bus.mem_ready) next = (state == FETCH) ? DECODE : EXEC;
                end
                DECODE: begin
                    case (op)
                        4'h1, 4'h4, 4'h5: next = OPERAND;
                        4'h2, 4'h3: next = EXEC;
                        4'hF: next = HALT;
                        default: next = FETCH;
                    endcase
                    set_illegal = (op >= 4'h6) && (op <= 4'hE);
                end
                EXEC: begin
                    next = (op == 4'h3) ? WB : FETCH;
                    case (op)
                        4'h1: begin
                            bus.imm_out_en = 1'b1;
                            bus.reg_dst = ir[11:8];
                            bus.reg_we = 1'b1;
                        end
                        4'h2: begin
                            bus.reg_out_en = 1'b1;
                            bus.reg_src = ir[7:4];
                            bus.reg_dst = ir[11:8];
                            bus.reg_we = 1'b1;
                        end
                        4'h3: begin
                            bus.reg_out_en = 1'b1;
                            bus.reg_src = ir[7:4];
                            bus.alu_en = 1'b1;
                            bus.alu_op = ir[2:0];
                        end
                        4'h4, 4'h5: begin
                            bus.imm_out_en = (op == 4'h4) || bus.flags[0];
                            bus.pc_load = (op == 4'h4) || bus.flags[0];
                        end
                        default: ;
                    endcase
                end
                WB: begin
                    next = FETCH;
                    bus.alu_en = 1'b1;
                    bus.alu_op = ir[2:0];
                    bus.reg_dst = ir[11:8];
                    bus.reg_we = 1'b1;
                end
                HALT: bus.halted = 1'b1;
                default: next = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed vectors with hand-computed expectations for instr_sequencer
module tb_instr_sequencer;
    logic clk = 1'b0;
    logic r = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    instr_sequencer_if bus ();
    instr_sequencer dut (.clk(clk), .r(r), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic rdy, input logic [15:0] word);
        bus.mem_ready = rdy;
        bus.mem_rdata = word;
        #1;
    endtask
    // WB is the only cycle where alu_en drives the bus without a register source
    always @(negedge clk)
        if (!r)
            chk("bus_excl", 16'(32'(bus.pc_out_en) + 32'(bus.imm_out_en) + 32'(bus.reg_out_en)
                + 32'(bus.alu_en & ~bus.reg_out_en) <= 1), 16'd1);
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        bus.flags = '0;
        tick();
        tick();
        r = 1'b0;
        drive(1'b0, 16'h0000);
        chk("rst_ir", bus.ir, 16'h0000);
        chk("rst_imm", bus.imm, 16'h0000);
        chk("rst_illegal", bus.illegal, 16'd0);
        chk("rst_strobes", {bus.pc_inc, bus.pc_load, bus.imm_out_en, bus.reg_out_en, bus.reg_we, bus.alu_en}, 16'd0);
        chk("rst_fetch", bus.mem_req, 16'd1);
        // LDI r3, 0xBEEF
        drive(1'b1, 16'h1300);
        chk("ldi_f_inc", bus.pc_inc, 16'd1);
        chk("ldi_f_pcout", bus.pc_out_en, 16'd1);
        tick();
        drive(1'b1, 16'hBEEF);
        chk("ldi_dec_ir", bus.ir, 16'h1300);
        chk("ldi_dec_quiet", {bus.mem_req, bus.pc_inc, bus.reg_we}, 16'd0);
        tick();
        drive(1'b1, 16'hBEEF);
        chk("ldi_op_inc", bus.pc_inc, 16'd1);
        tick();
        drive(1'b0, 16'h0000);
        chk("ldi_ex_imm", bus.imm, 16'hBEEF);
        chk("ldi_ex_immen", bus.imm_out_en, 16'd1);
        chk("ldi_ex_dst", bus.reg_dst, 16'd3);
        chk("ldi_ex_we", bus.reg_we, 16'd1);
        tick();
        drive(1'b0, 16'h0000);
        chk("ldi_refetch", bus.mem_req, 16'd1);
        // ALU r1 <- op5(r2)
        drive(1'b1, 16'h3125);
        tick();
        tick();
        drive(1'b0, 16'h0000);
        chk("alu_ex_src", bus.reg_src, 16'd2);
        chk("alu_ex_oe", bus.reg_out_en, 16'd1);
        chk("alu_ex_op", bus.alu_op, 16'd5);
        chk("alu_ex_we", bus.reg_we, 16'd0);
        tick();
        chk("alu_wb_dst", bus.reg_dst, 16'd1);
        chk("alu_wb_we", bus.reg_we, 16'd1);
        chk("alu_wb_oe", bus.reg_out_en, 16'd0);
        chk("alu_wb_op", bus.alu_op, 16'd5);
        chk("alu_wb_src", bus.reg_src, 16'd0);
        tick();
        // three wait cycles in FETCH, then MOV r4 <- r5
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h2450);
            chk("wait_req", {bus.mem_req, bus.pc_out_en}, 16'd3);
            chk("wait_inc", bus.pc_inc, 16'd0);
            chk("wait_ir", bus.ir, 16'h3125);
            tick();
        end
        drive(1'b1, 16'h2450);
        chk("wait_go_inc", bus.pc_inc, 16'd1);
        tick();
        drive(1'b0, 16'h0000);
        chk("mov_ir", bus.ir, 16'h2450);
        tick();
        chk("mov_ex", {bus.reg_out_en, bus.reg_src, bus.reg_dst, bus.reg_we}, {7'd0, 1'b1, 4'd5, 4'd4, 1'b1});
        tick();
        // JZ taken
        drive(1'b1, 16'h5000);
        tick();
        tick();
        drive(1'b1, 16'h0040);
        chk("jz_op_inc", bus.pc_inc, 16'd1);
        tick();
        bus.flags = 8'h01;
        drive(1'b0, 16'h0000);
        chk("jz_t_load", {bus.pc_load, bus.imm_out_en}, 16'd3);
        chk("jz_t_bus", bus.imm, 16'h0040);
        tick();
        // JZ not taken
        drive(1'b1, 16'h5000);
        tick();
        tick();
        drive(1'b1, 16'h0040);
        tick();
        bus.flags = 8'h00;
        drive(1'b0, 16'h0000);
        chk("jz_nt_quiet", {bus.pc_load, bus.imm_out_en, bus.reg_we, bus.mem_req}, 16'd0);
        tick();
        drive(1'b0, 16'h0000);
        chk("jz_nt_fetch", bus.mem_req, 16'd1);
        // illegal opcode then NOP
        drive(1'b1, 16'h7000);
        tick();
        drive(1'b0, 16'h0000);
        chk("ill_dec", bus.illegal, 16'd0);
        tick();
        drive(1'b0, 16'h0000);
        chk("ill_set", bus.illegal, 16'd1);
        chk("ill_fetch", bus.mem_req, 16'd1);
        drive(1'b1, 16'h0000);
        tick();
        tick();
        drive(1'b0, 16'h0000);
        chk("ill_sticky", bus.illegal, 16'd1);
        chk("nop_fetch", bus.mem_req, 16'd1);
        // reset during OPERAND of LDI
        drive(1'b1, 16'h1900);
        tick();
        tick();
        r = 1'b1;
        drive(1'b1, 16'h1234);
        chk("rst_op_inc", bus.pc_inc, 16'd0);
        tick();
        r = 1'b0;
        drive(1'b0, 16'h0000);
        chk("rst_op_imm", bus.imm, 16'h0000);
        chk("rst_op_ill", bus.illegal, 16'd0);
        chk("rst_op_ir", bus.ir, 16'h0000);
        chk("rst_op_strb", {bus.pc_inc, bus.pc_load, bus.imm_out_en, bus.reg_out_en, bus.reg_we, bus.alu_en}, 16'd0);
        chk("rst_op_fetch", {bus.mem_req, bus.pc_out_en}, 16'd3);
        // HLT
        drive(1'b1, 16'hF000);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i[0], 16'h1300);
            chk("halt_flag", bus.halted, 16'd1);
            chk("halt_quiet", {bus.mem_req, bus.pc_inc, bus.pc_out_en}, 16'd0);
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
